rv_timer: RTL and testbench

- Memory-mapped timer/compare peripheral and bus responder on the rv_core data bus (d_adr/d_we/d_re/d_dw/d_dr). The core is the initiator.
- Chip select is decoded at top level for the 32-byte window 0xffff0040–0xffff005f. Decode is `{d_adr[31:5],5'h0} == 32'hffff0040`.
- Provides a prescaled 32-bit counter, a compare match with one-shot or periodic mode, a level interrupt, and an optional free-running 64-bit cycle counter.

---
 rtl/rv_timer_pkg.sv | 34 +++
 rtl/rv_prescaler.sv | 21 ++
 rtl/rv_timer.sv | 125 ++++++++++++
 tb/tb_rv_timer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rv_timer_pkg.sv
// Shared types, register map and byte-lane helper for the rv_timer peripheral.
package rv_timer_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;

    localparam int unsigned TMR_PRE_W = 8;

    localparam u32_t       TMR_BASE   = 32'hffff0040;
    localparam logic [4:0] TMR_CTRL   = 5'h00;
    localparam logic [4:0] TMR_COUNT  = 5'h04;
    localparam logic [4:0] TMR_CMP    = 5'h08;
    localparam logic [4:0] TMR_STAT   = 5'h0c;
    localparam logic [4:0] TMR_CYC_LO = 5'h10;
    localparam logic [4:0] TMR_CYC_HI = 5'h14;

    typedef struct packed {
        logic [TMR_PRE_W-1:0] pre;
        logic                 ie;
        logic                 auto;
        logic                 en;
    } tmr_ctrl_t;

    // Replace only the byte lanes selected by be.
    function automatic u32_t be_merge(input u32_t old_val, input u32_t wdat, input u4_t be);
        u32_t res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = wdat[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_prescaler.sv
// Clock divider: tick_c is high one cycle in every pre+1 while en is set.
module rv_prescaler #(
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PRE_W-1:0] pre,
    output logic             tick_c
);

    logic [PRE_W-1:0] cnt_q;

    assign tick_c = en && (cnt_q == pre);

    always_ff @(posedge clk) begin
        if (reset || !en || tick_c) cnt_q <= '0;
        else                        cnt_q <= cnt_q + PRE_W'(1);
    end

endmodule

// File: rtl/rv_timer.sv
// Memory-mapped prescaled timer with compare/match interrupt on the rv_core data bus.
// Define RV_TIMER_CYCLE_EN to add the 64-bit free-running cycle counter at 0x10/0x14.
module rv_timer
    import rv_timer_pkg::*;
#(
    parameter int unsigned PRE_W   = TMR_PRE_W,
    parameter logic [31:0] CMP_RST = 32'hffffffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        irq
);

    tmr_ctrl_t  ctrl_q, ctrl_d;
    u32_t       count_q, count_d;
    u32_t       cmp_q, cmp_d;
    logic       match_q, match_d;
    u32_t       ctrl_img, ctrl_wimg, rdata_c;
    logic       tick_c, hit_c, wr_c, rd_c;
    logic [4:0] woff;
    logic       unused_ok;

    assign woff      = {adr[4:2], 2'b00};
    assign wr_c      = cs && (we != 4'h0);
    assign rd_c      = cs && re;
    assign ctrl_img  = 32'({ctrl_q.pre, 5'b0, ctrl_q.ie, ctrl_q.auto, ctrl_q.en});
    assign ctrl_wimg = be_merge(ctrl_img, dw, we);
    assign hit_c     = tick_c && (count_q == cmp_q);
    assign unused_ok = &{1'b0, adr[1:0], ctrl_wimg};

    rv_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk    (clk),
        .reset  (reset),
        .en     (ctrl_q.en),
        .pre    (PRE_W'(ctrl_q.pre)),
        .tick_c (tick_c)
    );

    // Tick update first, then CPU writes so they take priority.
    always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;
        if (tick_c) begin
            if (hit_c) begin
                if (ctrl_q.auto) count_d   = '0;
                else             ctrl_d.en = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
        if (wr_c && woff == TMR_STAT && we[0] && dw[0]) match_d = 1'b0;
        if (hit_c) match_d = 1'b1;
        if (wr_c && woff == TMR_CTRL) begin
            ctrl_d.en   = ctrl_wimg[0];
            ctrl_d.auto = ctrl_wimg[1];
            ctrl_d.ie   = ctrl_wimg[2];
            ctrl_d.pre  = TMR_PRE_W'(PRE_W'(ctrl_wimg[31:8]));
        end
        if (wr_c && woff == TMR_COUNT) count_d = be_merge(count_q, dw, we);
        if (wr_c && woff == TMR_CMP)   cmp_d   = be_merge(cmp_q, dw, we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= CMP_RST;
            match_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

`ifdef RV_TIMER_CYCLE_EN
    logic [63:0] cyc_q;
    u32_t        cyc_shadow_q;

    // A LO read snapshots the high word so a following HI read is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q        <= '0;
            cyc_shadow_q <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
            if (rd_c && woff == TMR_CYC_LO) cyc_shadow_q <= cyc_q[63:32];
        end
    end
`endif

    always_comb begin
        rdata_c = '0;
        case (woff)
            TMR_CTRL:   rdata_c = ctrl_img;
            TMR_COUNT:  rdata_c = count_q;
            TMR_CMP:    rdata_c = cmp_q;
            TMR_STAT:   rdata_c = {31'b0, match_q};
`ifdef RV_TIMER_CYCLE_EN
            TMR_CYC_LO: rdata_c = cyc_q[31:0];
            TMR_CYC_HI: rdata_c = cyc_shadow_q;
`endif
            default:    rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)     dr <= '0;
        else if (rd_c) dr <= rdata_c;
        else           dr <= '0;
    end

    // Both terms are flops, so irq cannot glitch.
    assign irq = match_q & ctrl_q.ie;

endmodule

// File: tb/tb_rv_timer.sv
// Directed self-checking bench for rv_timer; inputs change and outputs are sampled on negedge.
module tb_rv_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  adr = '0;
    logic        cs = 1'b0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic [31:0] dw = '0;
    logic [31:0] dr;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] d;

    rv_timer dut (
        .clk   (clk),
        .reset (reset),
        .adr   (adr),
        .cs    (cs),
        .we    (we),
        .re    (re),
        .dw    (dw),
        .dr    (dr),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] data, input logic [3:0] be);
        cs = 1'b1; we = be; adr = a; dw = data;
        @(negedge clk);
        cs = 1'b0; we = '0; dw = '0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] data);
        cs = 1'b1; re = 1'b1; adr = a;
        @(negedge clk);
        data = dr;
        cs = 1'b0; re = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        chk("rst_dr", dr, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        step();
        bus_rd(5'h00, d); chk("rst_ctrl", d, 32'h0);
        bus_rd(5'h04, d); chk("rst_count", d, 32'h0);
        step();
        chk("idle_dr_before", dr, 32'h0);
        bus_rd(5'h08, d); chk("rst_cmp", d, 32'hffffffff);
        step();
        chk("idle_dr_after", dr, 32'h0);
        bus_rd(5'h0c, d); chk("rst_stat", d, 32'h0);
        bus_rd(5'h1c, d); chk("rd_unmapped", d, 32'h0);
`ifndef RV_TIMER_CYCLE_EN
        bus_rd(5'h10, d); chk("cyc_lo_absent", d, 32'h0);
        bus_rd(5'h14, d); chk("cyc_hi_absent", d, 32'h0);
`endif

        // Periodic mode, PRE=0, COMPARE=5
        bus_wr(5'h08, 32'd5, 4'hf);
        bus_wr(5'h00, 32'h7, 4'hf);
        for (int i = 0; i < 8; i++) begin
            bus_rd(5'h04, d);
            chk("auto_count", d, (i < 6) ? 32'(i) : 32'(i - 6));
            chk("auto_irq", 32'(irq), (i >= 5) ? 32'h1 : 32'h0);
        end
        bus_wr(5'h0c, 32'h1, 4'hf);
        chk("w1c_irq_low", 32'(irq), 32'h0);
        repeat (2) step();
        chk("irq_still_low", 32'(irq), 32'h0);
        step();
        chk("irq_again", 32'(irq), 32'h1);
        bus_rd(5'h0c, d); chk("stat_set", d, 32'h1);
        bus_wr(5'h00, 32'h0, 4'hf);
        bus_wr(5'h0c, 32'h1, 4'hf);
        chk("irq_off", 32'(irq), 32'h0);

        // One-shot, PRE=3, COMPARE=2
        bus_wr(5'h04, 32'h0, 4'hf);
        bus_wr(5'h08, 32'd2, 4'hf);
        bus_wr(5'h00, 32'h0301, 4'hf);
        repeat (4) step();
        bus_rd(5'h04, d); chk("os_count_1a", d, 32'd1);
        repeat (2) step();
        bus_rd(5'h04, d); chk("os_count_1b", d, 32'd1);
        bus_rd(5'h04, d); chk("os_count_2", d, 32'd2);
        repeat (3) step();
        bus_rd(5'h0c, d); chk("os_match", d, 32'h1);
        bus_rd(5'h00, d); chk("os_en_cleared", d, 32'h0300);
        repeat (20) step();
        bus_rd(5'h04, d); chk("os_frozen", d, 32'd2);
        chk("os_irq_no_ie", 32'(irq), 32'h0);
        bus_wr(5'h0c, 32'h1, 4'hf);

        // Byte-lane write
        bus_wr(5'h08, 32'h0, 4'hf);
        bus_wr(5'h08, 32'hdeadabef, 4'b0010);
        bus_rd(5'h08, d); chk("byte_lane", d, 32'h0000ab00);

        // Wrap, write-over-tick, W1C vs new match
        bus_wr(5'h00, 32'h0, 4'hf);
        bus_wr(5'h0c, 32'h1, 4'hf);
        bus_wr(5'h04, 32'hffffffff, 4'hf);
        bus_wr(5'h08, 32'd3, 4'hf);
        bus_wr(5'h00, 32'h3, 4'hf);
        bus_rd(5'h04, d); chk("wrap_pre", d, 32'hffffffff);
        bus_rd(5'h04, d); chk("wrap_zero", d, 32'h0);
        repeat (2) step();
        bus_rd(5'h0c, d); chk("wrap_nomatch", d, 32'h0);
        bus_rd(5'h0c, d); chk("wrap_match", d, 32'h1);
        bus_rd(5'h04, d); chk("wrap_restart", d, 32'd1);
        bus_wr(5'h04, 32'h10, 4'hf);
        bus_rd(5'h04, d); chk("wr_beats_tick", d, 32'h10);
        bus_wr(5'h0c, 32'h1, 4'hf);
        bus_rd(5'h0c, d); chk("w1c_clear", d, 32'h0);
        bus_wr(5'h04, 32'd3, 4'hf);
        bus_wr(5'h0c, 32'h1, 4'hf);
        bus_rd(5'h0c, d); chk("set_beats_w1c", d, 32'h1);
        bus_rd(5'h04, d); chk("post_match_count", d, 32'd1);

        // Reset mid-count with irq high
        bus_wr(5'h00, 32'h7, 4'hf);
        chk("ie_irq_high", 32'(irq), 32'h1);
        reset = 1'b1;
        step();
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_dr", dr, 32'h0);
        reset = 1'b0;
        bus_rd(5'h04, d); chk("mid_rst_count", d, 32'h0);
        bus_rd(5'h08, d); chk("mid_rst_cmp", d, 32'hffffffff);
        bus_rd(5'h00, d); chk("mid_rst_ctrl", d, 32'h0);

`ifdef RV_TIMER_CYCLE_EN
        // Coherent 64-bit snapshot across the low-word carry
        force dut.cyc_q = 64'h00000000_fffffffe;
        release dut.cyc_q;
        repeat (3) step();
        bus_rd(5'h10, d); chk("cyc_lo", d, 32'h00000001);
        repeat (5) step();
        bus_rd(5'h14, d); chk("cyc_hi", d, 32'h00000001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
